tt_response_capture: RTL and testbench

//  On-chip response side of the exhaustive-pattern trojan test flow.
//  - Drives every input vector 0..2^N_IN-1 onto a single-output DUT.
//  - Samples the DUT output bit into a captured truth table.
//  - Compares the table against a golden table: flags mismatch and counts differing rows.
//  - Sits beside the DUT under test and replaces the file-dump testbench for in-system checks.

---
 rtl/tt_response_capture.sv | 154 +++++++++++++++
 tb/tb_tt_response_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_response_capture.sv
// tt_response_capture
//   Response side of an exhaustive-pattern test: walks every input vector
//   0..K-1 onto a single-output DUT, samples its output into a captured
//   truth table, then compares that table with a golden table latched at
//   start.
//
// Ports
//   CK        clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   start     one-cycle run request, honoured only while idle
//   abort     ends a run in progress without a done pulse
//   expected  golden truth table (bit i = response to vector i)
//   dut_out   single-bit response of the DUT
//   N_out     vector currently driven to the DUT (0 outside a run)
//   busy      high from accepted start until done
//   done      one-cycle pulse, results valid
//   tt        captured truth table
//   mismatch  OR-reduction of tt ^ golden, held until next start
//   err_cnt   number of differing rows, held until next start
module tt_response_capture #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1,
   localparam int K     = 1 << N_IN,
   localparam int CW    = $clog2(K + 1)
) (
   input  logic            CK,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [K-1:0]    expected,
   input  logic            dut_out,
   output logic [N_IN-1:0] N_out,
   output logic            busy,
   output logic            done,
   output logic [K-1:0]    tt,
   output logic            mismatch,
   output logic [CW-1:0]   err_cnt
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {IDLE, RUN, CMP} state_t;

   state_t          state;
   state_t          state_next;
   logic [N_IN-1:0] idx;
   logic [3:0]      cnt;
   logic [K-1:0]    exp_q;
   logic [K-1:0]    diff;
   logic [CW-1:0]   pop;
   logic            sample;

   // Row is sampled on the last cycle of its settle window.
   assign sample = (cnt == SETTLE_C);

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      N_out      = '0;
      case (state)
         IDLE: begin
            // start wins over a simultaneous abort here
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            N_out = idx;
            if (abort) begin
               state_next = IDLE;
            end else if (sample && (idx == '1)) begin
               state_next = CMP;
            end
         end
         CMP: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Row difference count, evaluated in CMP on the completed table.
   always_comb begin
      diff = tt ^ exp_q;
      pop  = '0;
      for (int i = 0; i < K; i++) begin
         pop = pop + CW'(diff[i]);
      end
   end

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         idx      <= '0;
         cnt      <= '0;
         exp_q    <= '0;
         tt       <= '0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  exp_q    <= expected;
                  tt       <= '0;
                  idx      <= '0;
                  cnt      <= '0;
                  mismatch <= 1'b0;
                  err_cnt  <= '0;
               end
            end
            RUN: begin
               // An aborted run keeps the rows already sampled.
               if (!abort) begin
                  if (!sample) begin
                     cnt <= cnt + 4'd1;
                  end else begin
                     tt[idx] <= dut_out;
                     cnt     <= '0;
                     // idx parks on the last row; no wrap-around
                     if (idx != '1) begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end
            CMP: begin
               if (!abort) begin
                  mismatch <= |diff;
                  err_cnt  <= pop;
                  done     <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_response_capture.sv
// tb_tt_response_capture
//   Two instances: A (N_IN=2, SETTLE=1) and B (N_IN=3, SETTLE=0).
//   Expected results are queued when a run is started and compared when
//   done pulses.
module tb_tt_response_capture;

   typedef struct {
      logic [7:0] tt;
      logic       mm;
      logic [3:0] err;
   } sb_t;

   logic       CK;
   logic       reset;

   logic       start_a, abort_a, dut_out_a;
   logic [3:0] expected_a;
   logic [1:0] N_out_a;
   logic       busy_a, done_a, mismatch_a;
   logic [3:0] tt_a;
   logic [2:0] err_cnt_a;
   int         mode_a;

   logic       start_b, abort_b, dut_out_b;
   logic [7:0] expected_b;
   logic [2:0] N_out_b;
   logic       busy_b, done_b, mismatch_b;
   logic [7:0] tt_b;
   logic [3:0] err_cnt_b;

   sb_t        sb_a[$];
   sb_t        sb_b[$];
   sb_t        mon_a, mon_b;
   int         done_cnt_a, done_cnt_b, runs_a, runs_b;
   int         n_checks, n_fail;

   tt_response_capture #(.N_IN(2), .SETTLE(1)) dut_a (
      .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
      .expected(expected_a), .dut_out(dut_out_a), .N_out(N_out_a),
      .busy(busy_a), .done(done_a), .tt(tt_a), .mismatch(mismatch_a),
      .err_cnt(err_cnt_a)
   );

   tt_response_capture #(.N_IN(3), .SETTLE(0)) dut_b (
      .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
      .expected(expected_b), .dut_out(dut_out_b), .N_out(N_out_b),
      .busy(busy_b), .done(done_b), .tt(tt_b), .mismatch(mismatch_b),
      .err_cnt(err_cnt_b)
   );

   // Circuits under test: AND / constant 1 for A, 3-input XOR for B.
   assign dut_out_a = (mode_a == 0) ? (N_out_a[1] & N_out_a[0]) : 1'b1;
   assign dut_out_b = ^N_out_b;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge CK) begin
      if (done_a === 1'b1) begin
         done_cnt_a++;
         if (sb_a.size() == 0) begin
            check("a_unexpected_done", 64'(1), 64'(0));
         end else begin
            mon_a = sb_a.pop_front();
            check("a_tt", 64'(tt_a), 64'(mon_a.tt));
            check("a_mismatch", 64'(mismatch_a), 64'(mon_a.mm));
            check("a_err_cnt", 64'(err_cnt_a), 64'(mon_a.err));
         end
      end
      if (done_b === 1'b1) begin
         done_cnt_b++;
         if (sb_b.size() == 0) begin
            check("b_unexpected_done", 64'(1), 64'(0));
         end else begin
            mon_b = sb_b.pop_front();
            check("b_tt", 64'(tt_b), 64'(mon_b.tt));
            check("b_mismatch", 64'(mismatch_b), 64'(mon_b.mm));
            check("b_err_cnt", 64'(err_cnt_b), 64'(mon_b.err));
         end
      end
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   // Starts a run on A and returns one step after done (done still high).
   task automatic run_a(input logic [3:0] exp, input logic [3:0] exp_tt, input int errs,
                        input bit seq, input bit with_abort);
      sb_t e;
      int  cyc;
      e.tt  = 8'(exp_tt);
      e.mm  = (errs != 0);
      e.err = 4'(errs);
      expected_a = exp;
      start_a    = 1'b1;
      abort_a    = with_abort;
      sb_a.push_back(e);
      runs_a++;
      step();
      start_a    = 1'b0;
      abort_a    = 1'b0;
      expected_a = ~exp;
      check("a_busy_e0", 64'(busy_a), 64'(1));
      check("a_done_low_e0", 64'(done_a), 64'(0));
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 50) begin
         if (seq && cyc < 8) check($sformatf("a_nout_%0d", cyc), 64'(N_out_a), 64'(cyc / 2));
         if (seq) start_a = (cyc == 3);
         step();
         cyc++;
      end
      start_a = 1'b0;
      check("a_latency", 64'(cyc), 64'(9));
      check("a_busy_at_done", 64'(busy_a), 64'(0));
   endtask

   task automatic run_b(input logic [7:0] exp, input logic [7:0] exp_tt, input int errs);
      sb_t e;
      int  cyc;
      e.tt  = exp_tt;
      e.mm  = (errs != 0);
      e.err = 4'(errs);
      expected_b = exp;
      start_b    = 1'b1;
      sb_b.push_back(e);
      runs_b++;
      step();
      start_b    = 1'b0;
      expected_b = ~exp;
      cyc = 0;
      while (done_b !== 1'b1 && cyc < 50) begin
         step();
         cyc++;
      end
      check("b_latency", 64'(cyc), 64'(9));
      check("b_busy_at_done", 64'(busy_b), 64'(0));
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      done_cnt_a = 0; done_cnt_b = 0; runs_a = 0; runs_b = 0;
      reset = 1'b0; mode_a = 0;
      start_a = 1'b0; abort_a = 1'b0; expected_a = '0;
      start_b = 1'b0; abort_b = 1'b0; expected_b = '0;
      #1 reset = 1'b1;
      #2;
      check("rst_nout", 64'(N_out_a), 64'(0));
      check("rst_busy", 64'(busy_a), 64'(0));
      check("rst_done", 64'(done_a), 64'(0));
      check("rst_tt", 64'(tt_a), 64'(0));
      check("rst_mismatch", 64'(mismatch_a), 64'(0));
      check("rst_err_cnt", 64'(err_cnt_a), 64'(0));
      repeat (2) @(posedge CK);
      #1 reset = 1'b0;
      step();

      // Matching run with N_out sequence and ignored start while busy,
      // then a mismatching run started in the done cycle.
      run_a(4'b1000, 4'b1000, 0, 1'b1, 1'b0);
      run_a(4'b1110, 4'b1000, 2, 1'b0, 1'b0);
      step();
      check("a_done_one_cycle", 64'(done_a), 64'(0));
      check("a_mismatch_held", 64'(mismatch_a), 64'(1));
      check("a_err_held", 64'(err_cnt_a), 64'(2));
      check("a_idle_busy", 64'(busy_a), 64'(0));

      // Abort after row 1 is sampled with a constant-1 response.
      mode_a     = 1;
      expected_a = 4'b0000;
      start_a    = 1'b1;
      step();
      start_a = 1'b0;
      repeat (4) @(posedge CK);
      #1;
      check("a_tt_before_abort", 64'(tt_a), 64'(4'b0011));
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      check("a_abort_busy", 64'(busy_a), 64'(0));
      check("a_abort_nout", 64'(N_out_a), 64'(0));
      check("a_abort_tt", 64'(tt_a), 64'(4'b0011));
      check("a_abort_mismatch", 64'(mismatch_a), 64'(0));
      check("a_abort_err", 64'(err_cnt_a), 64'(0));
      // abort while idle changes nothing
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      check("a_idle_abort_tt", 64'(tt_a), 64'(4'b0011));
      check("a_idle_abort_busy", 64'(busy_a), 64'(0));
      repeat (12) step();
      check("a_no_done_after_abort", 64'(done_cnt_a), 64'(2));

      // start together with abort in idle: start wins
      run_a(4'b1111, 4'b1111, 0, 1'b0, 1'b1);
      step();

      // Asynchronous reset in the middle of a run.
      mode_a     = 0;
      expected_a = 4'b1000;
      start_a    = 1'b1;
      step();
      start_a = 1'b0;
      repeat (3) @(posedge CK);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_nout", 64'(N_out_a), 64'(0));
      check("mid_rst_busy", 64'(busy_a), 64'(0));
      check("mid_rst_done", 64'(done_a), 64'(0));
      check("mid_rst_tt", 64'(tt_a), 64'(0));
      check("mid_rst_mismatch", 64'(mismatch_a), 64'(0));
      check("mid_rst_err", 64'(err_cnt_a), 64'(0));
      @(posedge CK);
      #1 reset = 1'b0;
      step();
      run_a(4'b1000, 4'b1000, 0, 1'b0, 1'b0);
      step();

      // Instance B: SETTLE=0, 3-input XOR.
      run_b(8'b10010110, 8'b10010110, 0);
      step();
      run_b(8'b00000000, 8'b10010110, 4);
      step();
      repeat (3) step();

      check("a_sb_empty", 64'(sb_a.size()), 64'(0));
      check("b_sb_empty", 64'(sb_b.size()), 64'(0));
      check("a_done_count", 64'(done_cnt_a), 64'(runs_a));
      check("b_done_count", 64'(done_cnt_b), 64'(runs_b));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
